self_test_monitor: RTL and testbench
====================================

// Module: self_test_monitor
// PURPOSE
//  Synthesizable, parametrised self-test controller for NPU on-chip test harnesses.
//  Launches the DUT NUM_RUNS times and counts per-channel result beats against an expected total.
//  Measures cycles per run and reports a 3-bit verdict plus a done flag.
//  Sits between the top-level test shim and the DUT; outputs go to the bench and to debug/JTAG readout.
// PARAMETERS
//  NUM_CH       4        result channels sampled per cycle (1..16)
//  CNT_W        32       width of result/perf counters
//  EXP_RESULTS  1024     expected result beats per run, summed over all channels
//  TIMEOUT      1000000  max cycles per run before the run is declared hung
//  NUM_RUNS     1        back-to-back runs per i_start (>=1)
// PORTS
//  clk             in   1        clock
//  reset           in   1        asynchronous, active-high reset
//  i_start         in   1        pulse: begin test sequence; ignored unless IDLE or DONE
//  o_dut_start     out  1        one-cycle pulse launching one DUT run
//  i_result_valid  in   NUM_CH   per-channel result beat this cycle
//  i_result_pass   in   NUM_CH   per-channel compare OK; qualified by valid
//  i_dut_done      in   1        DUT signals end of run (level or pulse)
//  o_test_status   out  3        verdict code (see BEHAVIOUR)
//  o_result_count  out  CNT_W    beats counted in current/last run
//  o_perf_counter  out  CNT_W    cycles summed over all completed runs
//  o_perf_max      out  CNT_W    longest single run in cycles
//  o_run_index     out  8        runs completed in this sequence
//  o_test_done     out  1        sequence finished; held until next i_start
// BEHAVIOUR
//  Reset: all outputs 0; status = ST_IDLE (0); FSM in IDLE. Async assert, sync release.
//  Status codes: 0 IDLE, 1 RUNNING, 2 PASS, 3 FAIL_MISMATCH, 4 FAIL_TIMEOUT,
//   5 FAIL_OVERCOUNT, 6 FAIL_UNDERCOUNT.
//  FSM states: IDLE -> LAUNCH -> RUN -> CHECK -> (LAUNCH | DONE).
//   IDLE/DONE + i_start: clear counters, o_run_index and o_test_done; go to LAUNCH; status=1.
//   LAUNCH: o_dut_start=1 for exactly one cycle; clear the run cycle counter and o_result_count; go to RUN.
//   RUN: run_cyc++ each cycle. o_result_count += popcount(i_result_valid), saturating at 2^CNT_W-1.
//    Any valid & ~pass -> sticky mismatch flag.
//    Exit to CHECK on the first of: i_dut_done; run_cyc == TIMEOUT-1 (timeout flag);
//     o_result_count + popcount > EXP_RESULTS (overcount flag).
//    Beats arriving in the exit cycle are counted.
//   CHECK (1 cycle): o_perf_counter += run_cyc (saturating); o_perf_max = max(o_perf_max, run_cyc);
//    o_run_index++.
//    Verdict priority: timeout > overcount > mismatch > undercount (count < EXP_RESULTS) > pass.
//    Any failure -> DONE immediately with that code. Otherwise run_index == NUM_RUNS -> DONE, status 2;
//     else -> LAUNCH.
//   DONE: o_test_done=1; all outputs frozen until i_start.
//  Latency: i_start -> o_dut_start = 1 cycle; i_dut_done -> o_test_done = 2 cycles (last run).
//  run_cyc counts from the first RUN cycle; a done on the first RUN cycle gives run_cyc = 1.
//  Inputs are ignored outside RUN, and i_start is ignored in LAUNCH/RUN/CHECK.
//  Reset mid-run returns to IDLE with all outputs 0; no o_dut_start is issued.
// STRUCTURE
//  Shared package self_test_pkg: status localparams ST_IDLE..ST_FAIL_UNDER, FSM state encoding.
//  Sub-module st_popcount #(.N(NUM_CH)): combinational popcount, output $clog2(NUM_CH+1) bits.
//  Counters, FSM and verdict logic stay in this module.
// TESTING
//  NUM_CH=4, EXP=16: 4 cycles all-valid/all-pass, then done -> status 2, count 16, done 2 cycles after.
//  Single beat with pass=0 on ch2 -> status 3, count 16.
//  TIMEOUT=50, DUT never signals done -> status 4 after 50 RUN cycles; perf_counter=50.
//  EXP=16, 5 all-valid cycles -> exit on the 5th cycle, status 5, count 20.
//  EXP=16, done after 12 beats -> status 6, count 12.
//  NUM_RUNS=3, runs of 10/20/15 cycles -> status 2, perf 45, max 20, run_index 3.
//  Reset asserted mid-run -> all outputs 0 next edge.
//  i_start during RUN -> ignored.

Source files
------------

// File: rtl/self_test_pkg.sv
// Shared status codes and FSM encoding for the on-chip self-test monitor.
package self_test_pkg;

  localparam logic [2:0] ST_IDLE          = 3'd0;
  localparam logic [2:0] ST_RUNNING       = 3'd1;
  localparam logic [2:0] ST_PASS          = 3'd2;
  localparam logic [2:0] ST_FAIL_MISMATCH = 3'd3;
  localparam logic [2:0] ST_FAIL_TIMEOUT  = 3'd4;
  localparam logic [2:0] ST_FAIL_OVER     = 3'd5;
  localparam logic [2:0] ST_FAIL_UNDER    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/st_popcount.sv
// Combinational population count of an N-bit vector.
module st_popcount #(
  parameter  int N = 4,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits_i,
  output logic [W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/self_test_monitor.sv
// Self-test controller: launches NUM_RUNS DUT runs, counts result beats per run,
// tracks run length statistics and reports a verdict code.
module self_test_monitor
  import self_test_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int EXP_RESULTS = 1024,
  parameter int TIMEOUT     = 1000000,
  parameter int NUM_RUNS    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_dut_start,
  input  logic [NUM_CH-1:0] i_result_valid,
  input  logic [NUM_CH-1:0] i_result_pass,
  input  logic              i_dut_done,
  output logic [2:0]        o_test_status,
  output logic [CNT_W-1:0]  o_result_count,
  output logic [CNT_W-1:0]  o_perf_counter,
  output logic [CNT_W-1:0]  o_perf_max,
  output logic [7:0]        o_run_index,
  output logic              o_test_done
);

  localparam int               PW        = $clog2(NUM_CH + 1);
  localparam logic [CNT_W:0]   EXP_X     = (CNT_W + 1)'(EXP_RESULTS);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       RUNS_LAST = 8'(NUM_RUNS - 1);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [2:0]       status_q, status_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] run_cyc_q, run_cyc_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [7:0]       idx_q, idx_d;
  logic             mism_q, mism_d;
  logic             to_q, to_d;
  logic             over_q, over_d;

  logic [PW-1:0]    pop;
  logic [CNT_W:0]   beat_sum;
  logic             over_now;
  logic             to_now;

  st_popcount #(.N(NUM_CH)) u_popcount (
    .bits_i  (i_result_valid),
    .count_o (pop)
  );

  // Overcount is judged on the unsaturated sum so a wrapped counter cannot hide it.
  assign beat_sum = {1'b0, count_q} + (CNT_W + 1)'(pop);
  assign over_now = (beat_sum > EXP_X);
  assign to_now   = (run_cyc_q == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      status_q  <= ST_IDLE;
      count_q   <= '0;
      run_cyc_q <= '0;
      perf_q    <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      mism_q    <= 1'b0;
      to_q      <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      count_q   <= count_d;
      run_cyc_q <= run_cyc_d;
      perf_q    <= perf_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      mism_q    <= mism_d;
      to_q      <= to_d;
      over_q    <= over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    count_d     = count_q;
    run_cyc_d   = run_cyc_q;
    perf_d      = perf_q;
    max_d       = max_q;
    idx_d       = idx_q;
    mism_d      = mism_q;
    to_d        = to_q;
    over_d      = over_q;
    o_dut_start = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d   = S_LAUNCH;
          status_d  = ST_RUNNING;
          count_d   = '0;
          run_cyc_d = '0;
          perf_d    = '0;
          max_d     = '0;
          idx_d     = '0;
        end
      end
      S_LAUNCH: begin
        o_dut_start = 1'b1;
        run_cyc_d   = '0;
        count_d     = '0;
        mism_d      = 1'b0;
        to_d        = 1'b0;
        over_d      = 1'b0;
        state_d     = S_RUN;
      end
      S_RUN: begin
        run_cyc_d = sat_add(run_cyc_q, CNT_W'(1));
        count_d   = beat_sum[CNT_W] ? {CNT_W{1'b1}} : beat_sum[CNT_W-1:0];
        if (|(i_result_valid & ~i_result_pass)) mism_d = 1'b1;
        if (to_now)   to_d   = 1'b1;
        if (over_now) over_d = 1'b1;
        if (i_dut_done || to_now || over_now) state_d = S_CHECK;
      end
      S_CHECK: begin
        perf_d  = sat_add(perf_q, run_cyc_q);
        if (run_cyc_q > max_q) max_d = run_cyc_q;
        idx_d   = idx_q + 8'd1;
        state_d = S_DONE;
        if (to_q)                         status_d = ST_FAIL_TIMEOUT;
        else if (over_q)                  status_d = ST_FAIL_OVER;
        else if (mism_q)                  status_d = ST_FAIL_MISMATCH;
        else if ({1'b0, count_q} < EXP_X) status_d = ST_FAIL_UNDER;
        else if (idx_q == RUNS_LAST)      status_d = ST_PASS;
        else                              state_d  = S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_test_status  = status_q;
  assign o_result_count = count_q;
  assign o_perf_counter = perf_q;
  assign o_perf_max     = max_q;
  assign o_run_index    = idx_q;
  assign o_test_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_self_test_monitor.sv
// Randomized and directed bench for self_test_monitor against a per-run reference model.
module tb_self_test_monitor;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int EXP  = 16;
  localparam int TMO  = 50;
  localparam int NRUN = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start;
  logic           o_dut_start;
  logic [NCH-1:0] i_result_valid;
  logic [NCH-1:0] i_result_pass;
  logic           i_dut_done;
  logic [2:0]     o_test_status;
  logic [CW-1:0]  o_result_count;
  logic [CW-1:0]  o_perf_counter;
  logic [CW-1:0]  o_perf_max;
  logic [7:0]     o_run_index;
  logic           o_test_done;

  self_test_monitor #(
    .NUM_CH(NCH), .CNT_W(CW), .EXP_RESULTS(EXP), .TIMEOUT(TMO), .NUM_RUNS(NRUN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .o_dut_start    (o_dut_start),
    .i_result_valid (i_result_valid),
    .i_result_pass  (i_result_pass),
    .i_dut_done     (i_dut_done),
    .o_test_status  (o_test_status),
    .o_result_count (o_result_count),
    .o_perf_counter (o_perf_counter),
    .o_perf_max     (o_perf_max),
    .o_run_index    (o_run_index),
    .o_test_done    (o_test_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] v;
    logic [NCH-1:0] p;
    logic           d;
    logic           s;
  } vec_t;

  vec_t plan [NRUN][TMO];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input vec_t x);
    i_result_valid = x.v;
    i_result_pass  = x.p;
    i_dut_done     = x.d;
    i_start        = x.s;
  endtask

  task automatic clear_plan();
    for (int r = 0; r < NRUN; r++)
      for (int k = 0; k < TMO; k++)
        plan[r][k] = '0;
  endtask

  // n all-valid/all-pass cycles, done raised on cycle done_k (-1: never)
  task automatic simple_run(input int r, input int n, input int done_k);
    for (int k = 0; k < n; k++) begin
      plan[r][k].v = '1;
      plan[r][k].p = '1;
    end
    if (done_k >= 0) plan[r][done_k].d = 1'b1;
  endtask

  // Reference: apply the run rules to the planned beats to find where the run
  // ends, how many beats it saw and which verdict (0 = clean) it earns.
  task automatic model_run(input int r, output int ncyc, output int cnt, output int verdict);
    int  c;
    bit  bad;
    bit  to;
    bit  ov;
    c = 0; bad = 0; ncyc = TMO; verdict = 0;
    for (int k = 0; k < TMO; k++) begin
      c += $countones(plan[r][k].v);
      if ((plan[r][k].v & ~plan[r][k].p) != 0) bad = 1;
      to = (k == TMO - 1);
      ov = (c > EXP);
      if (plan[r][k].d || to || ov) begin
        ncyc = k + 1;
        if (to)           verdict = 4;
        else if (ov)      verdict = 5;
        else if (bad)     verdict = 3;
        else if (c < EXP) verdict = 6;
        else              verdict = 0;
        break;
      end
    end
    cnt = c;
  endtask

  task automatic run_seq(input string name);
    int   ncyc, cnt, v, exp_st;
    int   exp_perf, exp_max, exp_idx, last_cnt;
    bit   fin;
    vec_t x;
    exp_perf = 0; exp_max = 0; exp_idx = 0; fin = 0; exp_st = 1; last_cnt = 0;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    chk({name, "/start_pulse"}, 32'(o_dut_start), 1);
    chk({name, "/running"}, 32'(o_test_status), 1);
    for (int r = 0; r < NRUN && !fin; r++) begin
      model_run(r, ncyc, cnt, v);
      for (int k = 0; k < ncyc; k++) begin
        @(negedge clk);
        drive(plan[r][k]);
      end
      @(negedge clk);
      drive('0);
      chk({name, "/run_count"}, 32'(o_result_count), 32'(cnt));
      chk({name, "/done_early"}, 32'(o_test_done), 0);
      exp_perf += ncyc;
      if (ncyc > exp_max) exp_max = ncyc;
      exp_idx++;
      last_cnt = cnt;
      if (v != 0) begin fin = 1; exp_st = v; end
      else if (exp_idx == NRUN) begin fin = 1; exp_st = 2; end
      @(negedge clk);
      if (!fin) chk({name, "/relaunch"}, 32'(o_dut_start), 1);
    end
    chk({name, "/test_done"}, 32'(o_test_done), 1);
    chk({name, "/status"}, 32'(o_test_status), 32'(exp_st));
    chk({name, "/count"}, 32'(o_result_count), 32'(last_cnt));
    chk({name, "/perf"}, 32'(o_perf_counter), 32'(exp_perf));
    chk({name, "/perf_max"}, 32'(o_perf_max), 32'(exp_max));
    chk({name, "/run_index"}, 32'(o_run_index), 32'(exp_idx));
    chk({name, "/no_launch"}, 32'(o_dut_start), 0);
    for (int k = 0; k < 2; k++) begin
      x.v = NCH'($urandom); x.p = NCH'($urandom); x.d = 1'($urandom); x.s = 1'b0;
      drive(x);
      @(negedge clk);
    end
    drive('0);
    chk({name, "/frozen_status"}, 32'(o_test_status), 32'(exp_st));
    chk({name, "/frozen_count"}, 32'(o_result_count), 32'(last_cnt));
    chk({name, "/frozen_done"}, 32'(o_test_done), 1);
  endtask

  task automatic random_plan();
    int rem, dk, used;
    bit biased;
    clear_plan();
    for (int r = 0; r < NRUN; r++) begin
      biased = ($urandom_range(0, 3) != 0);
      rem = EXP; dk = -1;
      for (int k = 0; k < TMO; k++) begin
        plan[r][k].v = NCH'($urandom);
        plan[r][k].p = ($urandom_range(0, 19) == 0) ? NCH'($urandom) : '1;
        if (biased) begin
          used = 0;
          for (int b = 0; b < NCH; b++) begin
            if (plan[r][k].v[b]) begin
              if (used >= rem) plan[r][k].v[b] = 1'b0;
              else used++;
            end
          end
          rem -= used;
          if (rem == 0 && dk < 0) dk = k + $urandom_range(0, 3);
          plan[r][k].d = (k == dk);
        end else begin
          plan[r][k].d = ($urandom_range(0, 11) == 0);
        end
        plan[r][k].s = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive('0);
    repeat (3) @(negedge clk);
    chk("rst/status", 32'(o_test_status), 0);
    chk("rst/count", 32'(o_result_count), 0);
    chk("rst/done", 32'(o_test_done), 0);
    chk("rst/dut_start", 32'(o_dut_start), 0);
    reset = 1'b0;
    @(negedge clk);

    clear_plan();
    for (int r = 0; r < NRUN; r++) simple_run(r, 4, 3);
    run_seq("pass");

    clear_plan();
    simple_run(0, 4, 3);
    plan[0][1].p = 4'b1011;
    run_seq("mismatch");

    clear_plan();
    run_seq("timeout");

    clear_plan();
    simple_run(0, 5, -1);
    run_seq("overcount");

    clear_plan();
    simple_run(0, 3, 2);
    run_seq("undercount");

    clear_plan();
    simple_run(0, 4, 9);
    simple_run(1, 4, 19);
    simple_run(2, 4, 14);
    plan[1][5].s = 1'b1;
    run_seq("multirun");

    // reset in the middle of the second run
    clear_plan();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive('{v: '1, p: '1, d: (k == 3), s: 1'b0});
    end
    @(negedge clk); drive('0);
    @(negedge clk);
    chk("midrst/relaunch", 32'(o_dut_start), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive('{v: '1, p: '1, d: 1'b0, s: 1'b0});
    end
    @(negedge clk);
    drive('0);
    chk("midrst/perf_before", 32'(o_perf_counter), 4);
    chk("midrst/idx_before", 32'(o_run_index), 1);
    reset = 1'b1;
    #1;
    chk("midrst/status", 32'(o_test_status), 0);
    chk("midrst/count", 32'(o_result_count), 0);
    chk("midrst/perf", 32'(o_perf_counter), 0);
    chk("midrst/max", 32'(o_perf_max), 0);
    chk("midrst/idx", 32'(o_run_index), 0);
    chk("midrst/done", 32'(o_test_done), 0);
    chk("midrst/dut_start", 32'(o_dut_start), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst/idle_start", 32'(o_dut_start), 0);
      chk("midrst/idle_status", 32'(o_test_status), 0);
    end

    for (int i = 0; i < 25; i++) begin
      random_plan();
      run_seq($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
